// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage: the fetch FSM state
// encoding, the default reset PC / NOP encoding, the PC step and a
// word-alignment helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        VALID   = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'hE1A0_0000;  // MOV r0,r0
    localparam logic [31:0] PC_STEP           = 32'd4;

    // Force a PC value onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel. The fetch unit is the
// master (issues requests); the memory is the slave (returns exactly one
// response per accepted request, at least one cycle later).
interface fetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_pc_reg.sv
// 32-bit program counter register. On load it takes either a redirect
// target or PC+4; every loaded value is word aligned.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        sel_target,
    input  logic [31:0] target,
    output logic [31:0] pc
);

    logic [31:0] pc_reg;
    logic [31:0] pc_next;

    // Select the candidate next PC; the increment wraps modulo 2^32.
    always_comb begin
        pc_next = word_align(sel_target ? target : (pc_reg + PC_STEP));
    end

    // PC register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= word_align(RESET_PC);
        end else if (load) begin
            pc_reg <= pc_next;
        end
    end

    assign pc = pc_reg;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns PCF, issues single-outstanding requests to a
// variable-latency instruction memory, applies branch/writeback redirects
// and holds one fetched instruction for Decode until it is consumed.
// Optional build macro FETCH_PERF_EN adds saturating perf counters
// perf_fetched / perf_discarded.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         StallF,
    input  logic         BranchTakenE,
    input  logic [31:0]  ALUResultE,
    input  logic         PCSrcW,
    input  logic [31:0]  ResultW,
    fetch_unit_if.master imem,
    output logic [31:0]  InstrF,
    output logic [31:0]  PCPlus4F,
    output logic         InstrValidF,
    output logic [31:0]  PCF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_fetched,
    output logic [31:0]  perf_discarded
`endif
);

    fetch_state_t state_reg;
    fetch_state_t state_next;
    fetch_state_t cur_state;
    logic         pending_reg;
    logic         pending_next;
    logic [31:0]  instr_reg;
    logic [31:0]  pcplus4_reg;

    logic         redirect;
    logic [31:0]  target;
    logic         req;
    logic         pc_load;
    logic         capture;

    assign redirect = BranchTakenE | PCSrcW;
    assign target   = BranchTakenE ? ALUResultE : ResultW;

    // A memory request still in flight when reset hit makes IDLE behave as
    // DISCARD, so that the late response is swallowed instead of accepted.
    assign cur_state = ((state_reg == IDLE) && pending_reg) ? DISCARD : state_reg;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Outstanding-request tracker, deliberately left out of reset so it
    // remembers a request that was in flight across a reset pulse.
    always_ff @(posedge clk) begin
        pending_reg <= pending_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = cur_state;
        unique case (cur_state)
            IDLE: begin
                if (!redirect && !StallF) state_next = WAIT;
            end
            WAIT: begin
                if (redirect)               state_next = imem.imem_rvalid ? IDLE : DISCARD;
                else if (imem.imem_rvalid)  state_next = VALID;
            end
            VALID: begin
                if (redirect)     state_next = IDLE;
                else if (!StallF) state_next = WAIT;
            end
            DISCARD: begin
                // The stale response ends DISCARD even under a new redirect;
                // otherwise no further response would ever arrive.
                if (imem.imem_rvalid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: request issue, PC load control and response capture.
    always_comb begin
        req          = reset && !redirect && !StallF &&
                       ((cur_state == IDLE) || (cur_state == VALID));
        pc_load      = redirect || ((cur_state == WAIT) && imem.imem_rvalid);
        capture      = (cur_state == WAIT) && imem.imem_rvalid && !redirect;
        pending_next = req || (pending_reg && !imem.imem_rvalid);
    end

    // Held instruction and its PC+4, updated only when a response is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_reg   <= NOP_INSTR;
            pcplus4_reg <= word_align(RESET_PC) + PC_STEP;
        end else if (capture) begin
            instr_reg   <= imem.imem_rdata;
            pcplus4_reg <= PCF + PC_STEP;
        end
    end

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .sel_target (redirect),
        .target     (target),
        .pc         (PCF)
    );

    assign imem.imem_req  = req;
    assign imem.imem_addr = PCF;
    assign InstrValidF    = (cur_state == VALID);
    assign InstrF         = (cur_state == VALID) ? instr_reg : NOP_INSTR;
    assign PCPlus4F       = pcplus4_reg;

`ifdef FETCH_PERF_EN
    logic        consumed;
    logic        dropped;
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_discarded_reg;

    assign consumed = (cur_state == VALID) && !StallF && !redirect;
    assign dropped  = ((cur_state == WAIT) && imem.imem_rvalid && redirect) ||
                      ((cur_state == DISCARD) && imem.imem_rvalid) ||
                      ((cur_state == VALID) && redirect);

    // Saturating event counters for delivered and thrown-away instructions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetched_reg   <= '0;
            perf_discarded_reg <= '0;
        end else begin
            if (consumed && (perf_fetched_reg != '1))
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            if (dropped && (perf_discarded_reg != '1))
                perf_discarded_reg <= perf_discarded_reg + 32'd1;
        end
    end

    assign perf_fetched   = perf_fetched_reg;
    assign perf_discarded = perf_discarded_reg;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Fetch stage of the pipelined core; sits directly upstream of the IF/ID register that feeds the controller's Instr[31:12].
- Owns PCF and issues one-outstanding-request fetches to a variable-latency instruction memory.
- Applies PC redirects from branches resolved in Execute and PC writes from Writeback.
- Presents a held instruction plus PCPlus4F to Decode, and honours StallF from the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, PCF value after reset
NOP_INSTR, 32'hE1A0_0000, InstrF value whenever InstrValidF=0 (MOV r0,r0)

Ports:
clk  input  1  core clock
reset  input  1  asynchronous, active-low reset
StallF  input  1  hazard unit: hold current fetch output, do not consume
BranchTakenE  input  1  branch resolved taken in Execute
ALUResultE  input  32  branch target
PCSrcW  input  1  PC written in Writeback
ResultW  input  32  Writeback PC value
imem_req  output  1  fetch request, accepted the same cycle
imem_addr  output  32  word-aligned fetch address
imem_rvalid  input  1  response valid, exactly once per request, ≥1 cycle after request
imem_rdata  input  32  fetched instruction
InstrF  output  32  instruction to the IF/ID register
PCPlus4F  output  32  address of InstrF + 4
InstrValidF  output  1  InstrF/PCPlus4F valid; consumed on a cycle with StallF=0
PCF  output  32  next fetch address

Behaviour:
- Reset (reset=0, asynchronous):
  - PCF=RESET_PC, state=IDLE, InstrF=NOP_INSTR, PCPlus4F=RESET_PC+4, InstrValidF=0, imem_req=0.
- States:
  - IDLE: no request outstanding, no instruction held.
  - WAIT: request outstanding.
  - VALID: instruction held.
  - DISCARD: outstanding response is stale.
- Redirect = BranchTakenE | PCSrcW. Target = ALUResultE if BranchTakenE, else ResultW (BranchTakenE wins when both are high). Redirect overrides StallF.
- imem_req is combinational, with imem_addr=PCF:
  - IDLE & ~StallF & ~redirect.
  - VALID & ~StallF & ~redirect (back-to-back issue).
- Transitions, with no redirect:
  - IDLE: req → WAIT.
  - WAIT: rvalid → VALID; latch InstrF=imem_rdata and PCPlus4F=PCF+4; PCF←PCF+4.
  - VALID: StallF → stay and hold all outputs. ~StallF → consumed, req issued → WAIT.
  - DISCARD: rvalid → IDLE; data dropped.
- Transitions on redirect (PCF←target in every case):
  - IDLE → IDLE.
  - WAIT without rvalid that cycle → DISCARD.
  - WAIT with rvalid the same cycle → IDLE; data dropped.
  - VALID → IDLE; held instruction dropped.
  - DISCARD → DISCARD.
- InstrValidF=1 only in VALID. In all other states InstrF=NOP_INSTR. PCPlus4F keeps its last value.
- Latency: req to InstrValidF is 1 cycle after rvalid. Best case is one instruction per 2 cycles.
- PC arithmetic is modulo 2^32 (0xFFFF_FFFC+4 → 0). Bits [1:0] of PCF are forced to 0 on every load.
- Reset asserted mid-WAIT: any response arriving after reset deasserts must be ignored. To guarantee this, the state after reset is DISCARD if a sticky "req in flight at reset" flag is set, otherwise IDLE.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds outputs perf_fetched[31:0] and perf_discarded[31:0]:
  - Both reset to 0 and saturate at 0xFFFF_FFFF.
  - perf_fetched increments on each VALID→consumed cycle.
  - perf_discarded increments on each dropped response or held instruction.
- When not defined: no such ports, no counter logic.

Decomposition:
- Package fetch_pkg holds:
  - The state enum (IDLE, WAIT, VALID, DISCARD), 2 bits.
  - The NOP_INSTR and RESET_PC defaults.
  - The PC step constant 32'd4.
- Sub-module fetch_pc_reg: 32-bit PC register with async active-low reset to RESET_PC, load enable, and a target/increment select.

Test Plan:
- Reset, memory latency 1: requests at 0x0 and 0x4 → InstrValidF pulses with InstrF=mem[0] then mem[1]; PCPlus4F=0x4 then 0x8.
- StallF=1 for 3 cycles while VALID with InstrF=0xE3A01005 → outputs constant, imem_req=0; StallF falls → next req at 0x8 the same cycle.
- Latency 4: BranchTakenE=1, ALUResultE=0x100 in cycle 2 of WAIT → state DISCARD, stale rdata dropped, next req at 0x100, first valid InstrF=mem[0x100].
- BranchTakenE=1 (0x200) and PCSrcW=1 (0x300) in the same cycle → PCF=0x200.
- PCF=0xFFFF_FFFC fetch completes → PCPlus4F=0x0, PCF=0x0.
- reset=0 while WAIT, rvalid arrives 2 cycles after release → response ignored, first req at RESET_PC, InstrValidF=0 until that response.
